pifo_sorted_array: RTL and testbench

- Single-bank, parametrised PIFO built as a sorted register array: rank-ordered shift register plus one comparator per slot.
- Successor to the skip-list PIFO front end, for small, deterministic-latency queues.
- Generalised in depth and widths. Adds what the previous generation lacks:
  - valid/ready handshakes on both sides;
  - occupancy and full/empty status;
  - a selectable overflow mode (backpressure or push-out with drop reporting);
  - strict FIFO order among equal ranks, without a timestamp field.
- Sits between a rank-computation stage and the egress scheduler.

---
 rtl/pifo_sorted_array_if.sv | 32 +++
 rtl/pifo_sorted_array.sv | 127 ++++++++++++
 tb/tb_pifo_sorted_array.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/pifo_sorted_array_if.sv
// Insert, dequeue and drop-report channels of the sorted-array PIFO.
// The master side feeds ranked elements and drains the head. The slave side is the queue itself.
interface pifo_sorted_array_if #(
    parameter int RANK_WIDTH = 10,
    parameter int META_WIDTH = 20
);
    logic                  ins_valid;
    logic                  ins_ready;
    logic [RANK_WIDTH-1:0] ins_rank;
    logic [META_WIDTH-1:0] ins_meta;

    logic                  deq_valid;
    logic                  deq_ready;
    logic [RANK_WIDTH-1:0] deq_rank;
    logic [META_WIDTH-1:0] deq_meta;

    logic                  drop_valid;
    logic [RANK_WIDTH-1:0] drop_rank;
    logic [META_WIDTH-1:0] drop_meta;

    modport master (
        output ins_valid, ins_rank, ins_meta, deq_ready,
        input  ins_ready, deq_valid, deq_rank, deq_meta,
        input  drop_valid, drop_rank, drop_meta
    );

    modport slave (
        input  ins_valid, ins_rank, ins_meta, deq_ready,
        output ins_ready, deq_valid, deq_rank, deq_meta,
        output drop_valid, drop_rank, drop_meta
    );
endinterface

// File: rtl/pifo_sorted_array.sv
// Sorted register-array PIFO: slot 0 is the head, and valid slots are packed from slot 0.
// Each slot compares its rank against the incoming rank; equal ranks queue behind older entries.
module pifo_sorted_array #(
    parameter int DEPTH      = 16,
    parameter int RANK_WIDTH = 10,
    parameter int META_WIDTH = 20,
    parameter int DROP_MODE  = 0,
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    pifo_sorted_array_if.slave   bus,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 full,
    output logic                 empty
);
    logic [DEPTH-1:0]      slot_v;
    logic [RANK_WIDTH-1:0] slot_r [DEPTH];
    logic [META_WIDTH-1:0] slot_m [DEPTH];

    logic [DEPTH-1:0]      pp_v;
    logic [RANK_WIDTH-1:0] pp_r [DEPTH];
    logic [META_WIDTH-1:0] pp_m [DEPTH];

    logic [DEPTH-1:0]      le;
    logic [DEPTH-1:0]      nx_v;
    logic [RANK_WIDTH-1:0] nx_r [DEPTH];
    logic [META_WIDTH-1:0] nx_m [DEPTH];

    logic                  pop;
    logic                  ins_fire;
    logic                  overflow;
    logic [CNT_WIDTH-1:0]  count_nx;

    logic                  drop_v_q;
    logic [RANK_WIDTH-1:0] drop_r_q;
    logic [META_WIDTH-1:0] drop_m_q;

    assign full  = (count == CNT_WIDTH'(DEPTH));
    assign empty = (count == '0);

    assign bus.ins_ready = (DROP_MODE != 0) ? 1'b1 : ~full;
    assign pop           = slot_v[0] & bus.deq_ready;
    assign ins_fire      = bus.ins_valid & bus.ins_ready;
    // Only reachable in push-out mode: backpressure holds ins_ready low while full.
    assign overflow      = ins_fire & full & ~pop;

    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_slot
            // Post-pop view of the array; the insert position is computed against it.
            if (i == DEPTH - 1) begin : g_tail
                assign pp_v[i] = pop ? 1'b0 : slot_v[i];
                assign pp_r[i] = pop ? '0   : slot_r[i];
                assign pp_m[i] = pop ? '0   : slot_m[i];
            end else begin : g_body
                assign pp_v[i] = pop ? slot_v[i+1] : slot_v[i];
                assign pp_r[i] = pop ? slot_r[i+1] : slot_r[i];
                assign pp_m[i] = pop ? slot_m[i+1] : slot_m[i];
            end

            assign le[i] = pp_v[i] & (pp_r[i] <= bus.ins_rank);

            if (i == 0) begin : g_head
                assign nx_v[i] = ins_fire | pp_v[i];
                assign nx_r[i] = (ins_fire && !le[i]) ? bus.ins_rank : pp_r[i];
                assign nx_m[i] = (ins_fire && !le[i]) ? bus.ins_meta : pp_m[i];
            end else begin : g_rest
                assign nx_v[i] = ins_fire ? pp_v[i-1] : pp_v[i];
                assign nx_r[i] = (!ins_fire || le[i]) ? pp_r[i]
                               : le[i-1]              ? bus.ins_rank
                               :                        pp_r[i-1];
                assign nx_m[i] = (!ins_fire || le[i]) ? pp_m[i]
                               : le[i-1]              ? bus.ins_meta
                               :                        pp_m[i-1];
            end
        end
    endgenerate

    always_comb begin
        count_nx = count;
        if (ins_fire && !pop && !full)
            count_nx = count + CNT_WIDTH'(1);
        else if (pop && !ins_fire)
            count_nx = count - CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_v <= '0;
            count  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                slot_r[k] <= '0;
                slot_m[k] <= '0;
            end
        end else begin
            slot_v <= nx_v;
            count  <= count_nx;
            for (int k = 0; k < DEPTH; k++) begin
                slot_r[k] <= nx_r[k];
                slot_m[k] <= nx_m[k];
            end
        end
    end

    // On overflow, le of the tail tells whether the newcomer lost (rank >= tail) or evicted the tail.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_v_q <= 1'b0;
            drop_r_q <= '0;
            drop_m_q <= '0;
        end else begin
            drop_v_q <= overflow;
            if (overflow) begin
                drop_r_q <= le[DEPTH-1] ? bus.ins_rank : slot_r[DEPTH-1];
                drop_m_q <= le[DEPTH-1] ? bus.ins_meta : slot_m[DEPTH-1];
            end
        end
    end

    assign bus.deq_valid  = slot_v[0];
    assign bus.deq_rank   = slot_r[0];
    assign bus.deq_meta   = slot_m[0];
    assign bus.drop_valid = drop_v_q;
    assign bus.drop_rank  = drop_r_q;
    assign bus.drop_meta  = drop_m_q;
endmodule

// File: tb/tb_pifo_sorted_array.sv
// Directed bench: a backpressure instance (a) and a push-out instance (b), both DEPTH=4.
// Expected values are computed by hand from the insert and pop sequences.
module tb_pifo_sorted_array;
    localparam int RW = 10;
    localparam int MW = 20;

    logic       clk;
    logic       rst;
    logic [2:0] count_a, count_b;
    logic       full_a, full_b, empty_a, empty_b;

    int n_checks = 0;
    int n_fail   = 0;

    pifo_sorted_array_if #(.RANK_WIDTH(RW), .META_WIDTH(MW)) a_if ();
    pifo_sorted_array_if #(.RANK_WIDTH(RW), .META_WIDTH(MW)) b_if ();

    pifo_sorted_array #(.DEPTH(4), .RANK_WIDTH(RW), .META_WIDTH(MW), .DROP_MODE(0)) u_bp (
        .clk   (clk),
        .rst   (rst),
        .bus   (a_if),
        .count (count_a),
        .full  (full_a),
        .empty (empty_a)
    );

    pifo_sorted_array #(.DEPTH(4), .RANK_WIDTH(RW), .META_WIDTH(MW), .DROP_MODE(1)) u_po (
        .clk   (clk),
        .rst   (rst),
        .bus   (b_if),
        .count (count_b),
        .full  (full_b),
        .empty (empty_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input int r, input int m);
        a_if.ins_valid = 1'b1;
        a_if.ins_rank  = RW'(r);
        a_if.ins_meta  = MW'(m);
        cyc();
        a_if.ins_valid = 1'b0;
    endtask

    task automatic push_b(input int r, input int m);
        b_if.ins_valid = 1'b1;
        b_if.ins_rank  = RW'(r);
        b_if.ins_meta  = MW'(m);
        cyc();
        b_if.ins_valid = 1'b0;
    endtask

    task automatic pop_a(input string tag, input int r, input int m);
        check({tag, "_vld"},  32'(a_if.deq_valid), 32'd1);
        check({tag, "_rank"}, 32'(a_if.deq_rank),  32'(r));
        check({tag, "_meta"}, 32'(a_if.deq_meta),  32'(m));
        a_if.deq_ready = 1'b1;
        cyc();
        a_if.deq_ready = 1'b0;
    endtask

    task automatic pop_b(input string tag, input int r, input int m);
        check({tag, "_vld"},  32'(b_if.deq_valid), 32'd1);
        check({tag, "_rank"}, 32'(b_if.deq_rank),  32'(r));
        check({tag, "_meta"}, 32'(b_if.deq_meta),  32'(m));
        b_if.deq_ready = 1'b1;
        cyc();
        b_if.deq_ready = 1'b0;
    endtask

    initial begin
        int r1[4];
        int m1[4];
        r1 = '{7, 3, 9, 3};
        m1 = '{'hA, 'hB, 'hC, 'hD};

        rst = 1'b0;
        a_if.ins_valid = 1'b0; a_if.ins_rank = '0; a_if.ins_meta = '0; a_if.deq_ready = 1'b0;
        b_if.ins_valid = 1'b0; b_if.ins_rank = '0; b_if.ins_meta = '0; b_if.deq_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        check("rst_count",  32'(count_a),         32'd0);
        check("rst_empty",  32'(empty_a),         32'd1);
        check("rst_full",   32'(full_a),          32'd0);
        check("rst_deqv",   32'(a_if.deq_valid),  32'd0);
        check("rst_rdy_a",  32'(a_if.ins_ready),  32'd1);
        check("rst_rdy_b",  32'(b_if.ins_ready),  32'd1);
        check("rst_rank",   32'(a_if.deq_rank),   32'd0);
        check("rst_dropv",  32'(b_if.drop_valid), 32'd0);

        @(negedge clk);
        rst = 1'b1;
        cyc();

        // Ordering with FIFO tie-break and backpressure
        a_if.ins_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a_if.ins_rank = RW'(r1[k]);
            a_if.ins_meta = MW'(m1[k]);
            cyc();
            if (k == 0) check("lat_head7", 32'(a_if.deq_rank), 32'd7);
        end
        a_if.ins_valid = 1'b0;
        check("fill_count", 32'(count_a),        32'd4);
        check("fill_full",  32'(full_a),         32'd1);
        check("fill_rdy",   32'(a_if.ins_ready), 32'd0);

        push_a(0, 'h99);
        check("bp_count", 32'(count_a),       32'd4);
        check("bp_head",  32'(a_if.deq_rank), 32'd3);

        pop_a("p1", 3, 'hB);
        pop_a("p2", 3, 'hD);
        pop_a("p3", 7, 'hA);
        pop_a("p4", 9, 'hC);
        check("drain_empty", 32'(empty_a),        32'd1);
        check("drain_deqv",  32'(a_if.deq_valid), 32'd0);

        // Insert while empty with deq_ready high: nothing pops
        a_if.deq_ready = 1'b1;
        push_a(5, 'h5);
        a_if.deq_ready = 1'b0;
        check("emp_deqv",  32'(a_if.deq_valid), 32'd1);
        check("emp_rank",  32'(a_if.deq_rank),  32'd5);
        check("emp_count", 32'(count_a),        32'd1);
        pop_a("emp_pop", 5, 'h5);

        // Push-out: full with simultaneous pop and insert
        push_b(1, 'h11); push_b(2, 'h12); push_b(3, 'h13); push_b(4, 'h14);
        check("po_full", 32'(full_b), 32'd1);
        b_if.deq_ready = 1'b1;
        push_b(0, 'h10);
        b_if.deq_ready = 1'b0;
        check("pi_count", 32'(count_b),         32'd4);
        check("pi_drop",  32'(b_if.drop_valid), 32'd0);
        pop_b("pi0", 0, 'h10);
        pop_b("pi2", 2, 'h12);
        pop_b("pi3", 3, 'h13);
        pop_b("pi4", 4, 'h14);
        check("pi_empty", 32'(empty_b), 32'd1);

        // Push-out: reject incoming equal to tail, then evict tail, back to back
        push_b(1, 'h21); push_b(2, 'h22); push_b(3, 'h23); push_b(8, 'h28);
        check("po_rdy_full", 32'(b_if.ins_ready), 32'd1);
        b_if.ins_valid = 1'b1;
        b_if.ins_rank  = RW'(8);
        b_if.ins_meta  = MW'('h77);
        cyc();
        check("rej_dropv", 32'(b_if.drop_valid), 32'd1);
        check("rej_rank",  32'(b_if.drop_rank),  32'd8);
        check("rej_meta",  32'(b_if.drop_meta),  32'h77);
        check("rej_count", 32'(count_b),         32'd4);
        b_if.ins_rank = RW'(5);
        b_if.ins_meta = MW'('h55);
        cyc();
        b_if.ins_valid = 1'b0;
        check("ev_dropv", 32'(b_if.drop_valid), 32'd1);
        check("ev_rank",  32'(b_if.drop_rank),  32'd8);
        check("ev_meta",  32'(b_if.drop_meta),  32'h28);
        check("ev_count", 32'(count_b),         32'd4);
        cyc();
        check("ev_pulse_end", 32'(b_if.drop_valid), 32'd0);
        pop_b("ev1", 1, 'h21);
        pop_b("ev2", 2, 'h22);
        pop_b("ev3", 3, 'h23);
        pop_b("ev5", 5, 'h55);
        check("ev_empty", 32'(empty_b), 32'd1);

        // Asynchronous reset mid-cycle
        push_a(4, 'h1); push_a(5, 'h2); push_a(6, 'h3);
        check("ar_pre_count", 32'(count_a), 32'd3);
        #3;
        rst = 1'b0;
        #1;
        check("ar_count", 32'(count_a),        32'd0);
        check("ar_empty", 32'(empty_a),        32'd1);
        check("ar_deqv",  32'(a_if.deq_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        cyc();
        push_a(2, 'h2);
        check("ar_resume_rank",  32'(a_if.deq_rank), 32'd2);
        check("ar_resume_count", 32'(count_a),       32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
